// File: rtl/ttl_cen_gen_sync_pkg.sv
// rtl/ttl_cen_gen_sync_pkg.sv - shared TTL pseudo-clock state encoding and constants
package ttl_cen_gen_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } cen_state_e;

    // Shortest legal pseudo-clock period: one high cycle plus one low cycle.
    localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/ttl_cen_gen_sync.sv
// rtl/ttl_cen_gen_sync.sv - registered clock-enable pseudo-clock generator with whole-period Run gating
module ttl_cen_gen_sync
    import ttl_cen_gen_sync_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic [CNT_W-1:0] Div,
    input  logic [CNT_W-1:0] High,
    output logic             Cen,
    output logic             Cen_rise,
    output logic             Cen_fall,
    output logic [CNT_W-1:0] Phase,
    output logic             Busy
);

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_PERIOD - 1);

    cen_state_e       state_q;
    logic [CNT_W-1:0] last_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] phase_q;
    logic             cen_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;

    logic [CNT_W-1:0] last_d;
    logic [CNT_W-1:0] high_d;

    // Shadow holds P-1 rather than P so a full-scale Div never overflows CNT_W.
    always_comb begin
        last_d = (Div < MIN_LAST) ? MIN_LAST : Div;
        high_d = (High == '0) ? CNT_W'(1) : High;
        if (high_d > last_d) begin
            high_d = last_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
            high_q  <= '0;
            phase_q <= '0;
            cen_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cen_q   <= 1'b0;
                    phase_q <= '0;
                    busy_q  <= 1'b0;
                    if (Run) begin
                        state_q <= ST_HIGH;
                        last_q  <= last_d;
                        high_q  <= high_d;
                        cen_q   <= 1'b1;
                        rise_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    phase_q <= phase_q + 1'b1;
                    if (phase_q == high_q - 1'b1) begin
                        state_q <= ST_LOW;
                        cen_q   <= 1'b0;
                        fall_q  <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (phase_q != last_q) begin
                        phase_q <= phase_q + 1'b1;
                    end else if (Run) begin
                        // Run is only honoured here so periods are never cut short.
                        state_q <= ST_HIGH;
                        last_q  <= last_d;
                        high_q  <= high_d;
                        phase_q <= '0;
                        cen_q   <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        phase_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    phase_q <= '0;
                    cen_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Cen      = cen_q;
    assign Cen_rise = rise_q;
    assign Cen_fall = fall_q;
    assign Phase    = phase_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_ttl_cen_gen_sync.sv
// tb/tb_ttl_cen_gen_sync.sv - scoreboard bench for ttl_cen_gen_sync against a per-period plan model
module tb_ttl_cen_gen_sync;

    localparam int CNT_W = 8;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             Run = 1'b0;
    logic [CNT_W-1:0] Div = '0;
    logic [CNT_W-1:0] High = '0;
    logic             Cen;
    logic             Cen_rise;
    logic             Cen_fall;
    logic [CNT_W-1:0] Phase;
    logic             Busy;

    ttl_cen_gen_sync #(.CNT_W(CNT_W)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Run      (Run),
        .Div      (Div),
        .High     (High),
        .Cen      (Cen),
        .Cen_rise (Cen_rise),
        .Cen_fall (Cen_fall),
        .Phase    (Phase),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic             cen;
        logic             rise;
        logic             fall;
        logic             busy;
        logic [CNT_W-1:0] phase;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   remain = 0;
    bit   mon_en = 1'b0;

    // Reference: at each period start, lay out the whole period's expected cycles.
    always @(posedge Clk) begin
        int p;
        int h;
        if (mon_en && Reset_n) begin
            if (remain > 0) begin
                remain--;
            end else if (Run) begin
                p = ((int'(Div) < 1) ? 1 : int'(Div)) + 1;
                h = (int'(High) < 1) ? 1 : int'(High);
                if (h > p - 1) h = p - 1;
                for (int i = 0; i < p; i++) begin
                    obs_t o;
                    o.cen   = (i < h);
                    o.rise  = (i == 0);
                    o.fall  = (i == h);
                    o.busy  = 1'b1;
                    o.phase = CNT_W'(i);
                    exp_q.push_back(o);
                end
                remain = p - 1;
            end else begin
                exp_q.push_back('0);
            end
        end
    end

    always @(negedge Clk) begin
        obs_t a;
        obs_t e;
        if (mon_en && Reset_n) begin
            a = {Cen, Cen_rise, Cen_fall, Busy, Phase};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow t=%0t got cen/rise/fall/busy=%b%b%b%b phase=%0d, required an expected entry",
                         $time, a.cen, a.rise, a.fall, a.busy, a.phase);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle t=%0t got cen/rise/fall/busy=%b%b%b%b phase=%0d, required %b%b%b%b phase=%0d",
                             $time, a.cen, a.rise, a.fall, a.busy, a.phase,
                             e.cen, e.rise, e.fall, e.busy, e.phase);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Pulse reset between clock edges and check the outputs clear without a clock.
    task automatic do_reset();
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({Cen, Cen_rise, Cen_fall, Busy, Phase} !== 12'b0) begin
            n_bad++;
            $display("FAIL reset_async t=%0t got cen/rise/fall/busy=%b%b%b%b phase=%0d, required all zero",
                     $time, Cen, Cen_rise, Cen_fall, Busy, Phase);
        end
        #1 Reset_n = 1'b1;
        exp_q.delete();
        remain = 0;
        exp_q.push_back('0);
        mon_en = 1'b1;
    endtask

    initial begin
        do_reset();

        Div = 8'd3; High = 8'd2; Run = 1'b1;
        cyc(20);
        Run = 1'b0;
        cyc(10);

        Div = 8'd0; High = 8'd0; Run = 1'b1;
        cyc(12);
        Run = 1'b0;
        cyc(6);

        Div = 8'd4; High = 8'd9; Run = 1'b1;
        cyc(15);
        Run = 1'b0;
        cyc(8);

        Div = 8'd5; High = 8'd3; Run = 1'b1;
        cyc(2);
        Run = 1'b0;
        cyc(12);

        Div = 8'd3; High = 8'd2; Run = 1'b1;
        cyc(3);
        Div = 8'd7;
        cyc(20);
        Run = 1'b0;
        cyc(12);

        Div = 8'd6; High = 8'd4; Run = 1'b1;
        for (int i = 0; i < 50 && !Cen; i++) cyc(1);
        n_cmp++;
        if (!Cen) begin
            n_bad++;
            $display("FAIL wait_high got cen=%b, required 1 within 50 cycles", Cen);
        end
        do_reset();
        cyc(20);
        Run = 1'b0;
        cyc(12);

        Div = 8'd255; High = 8'd200; Run = 1'b1;
        cyc(3);
        Run = 1'b0;
        cyc(260);

        for (int k = 0; k < 1500; k++) begin
            @(negedge Clk);
            Run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) begin
                Div  = CNT_W'($urandom_range(0, 12));
                High = CNT_W'($urandom_range(0, 14));
            end
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        Run = 1'b0;
        cyc(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
